// File: rtl/div_job_queue.sv
// div_job_queue: operand FIFO and result buffer around the 8-bit bit-slice divider.
// Jobs are queued as {dividend, divisor} and issued to the divider one at a time.
// A zero divisor never reaches the divider: its result is produced directly.
// Results are held in one output register until the consumer accepts them.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | no job in flight; pops the FIFO head when the result reg is free
//   ISSUE   | Req high, waiting for Done; captures Quotient/Remainder on Done
//   RELEASE | Req low, waiting for Done to drop before accepting another job
module div_job_queue #(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [7:0] InDividend,
    input  logic [7:0] InDivisor,
    output logic       Req,
    output logic [7:0] Operand1,
    output logic [7:0] Operand2,
    input  logic       Done,
    input  logic [7:0] Quotient,
    input  logic [7:0] Remainder,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [7:0] OutQuotient,
    output logic [7:0] OutRemainder,
    output logic       OutDivZero,
    output logic       Busy
);

    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          push;
    logic          pop;
    logic          out_free;
    logic          latch_ops;
    logic          load_res;
    logic [7:0]    res_q;
    logic [7:0]    res_r;
    logic          res_dz;
    logic [7:0]    head_dvd;
    logic [7:0]    head_dvs;

    // InReady depends only on the registered count, so a same-cycle pop
    // never re-opens a full FIFO.
    assign InReady            = (count < FULL);
    assign push               = InValid && InReady;
    assign out_free           = !OutValid || OutReady;
    assign {head_dvd, head_dvs} = mem[rd_ptr];
    assign Req                = (state == ISSUE);
    assign Busy               = (state != IDLE) || (count != '0);

    // FIFO storage; written on push only, contents need no reset.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= {InDividend, InDivisor};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state, FIFO pop and result-register load selection.
    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        latch_ops = 1'b0;
        load_res  = 1'b0;
        res_q     = 8'd0;
        res_r     = 8'd0;
        res_dz    = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && out_free) begin
                    pop = 1'b1;
                    if (head_dvs == 8'd0) begin
                        load_res = 1'b1;
                        res_q    = 8'hFF;
                        res_r    = head_dvd;
                        res_dz   = 1'b1;
                    end else begin
                        latch_ops = 1'b1;
                        state_nx  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Nothing else loads the result register while a job is in
                // flight, so it is always free when Done arrives.
                if (Done) begin
                    load_res = 1'b1;
                    res_q    = Quotient;
                    res_r    = Remainder;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                // A Done still high from the last job must not complete the next.
                if (!Done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Divider operands, held from issue until the FSM returns to IDLE.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Operand1 <= 8'd0;
            Operand2 <= 8'd0;
        end else if (latch_ops) begin
            Operand1 <= head_dvd;
            Operand2 <= head_dvs;
        end
    end

    // Result register; a reload wins over a same-cycle consume.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            OutValid     <= 1'b0;
            OutQuotient  <= 8'd0;
            OutRemainder <= 8'd0;
            OutDivZero   <= 1'b0;
        end else if (load_res) begin
            OutValid     <= 1'b1;
            OutQuotient  <= res_q;
            OutRemainder <= res_r;
            OutDivZero   <= res_dz;
        end else if (OutValid && OutReady) begin
            OutValid     <= 1'b0;
        end
    end

endmodule
